sn193_ctrl: RTL and testbench

//  Synchronous controller that drives an SN74XX193-style 4-bit up/down counter.

---
 rtl/sn193_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_sn193_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn193_ctrl.sv
// Clocked command front-end for an SN74XX193-style asynchronous up/down counter.
// Turns commands into timed strobes, then checks the synchronized readback against the tracked value.
module sn193_ctrl #(
   parameter int unsigned PULSE_W = 4,
   parameter int unsigned GAP_W   = 4
) (
   input  logic       clk,
   input  logic       nclr,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [3:0] cmd_cnt,
   input  logic [3:0] cmd_data,
   output logic       up,
   output logic       down,
   output logic       nload,
   output logic       clr,
   output logic [3:0] d,
   input  logic [3:0] q,
   input  logic       co,
   input  logic       bo,
   output logic       done,
   output logic [3:0] result,
   output logic       err,
   output logic       co_seen,
   output logic       bo_seen
);

   localparam int unsigned TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int unsigned TW   = (TMAX < 3) ? 2 : $clog2(TMAX + 1);

   localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_W - 1);
   localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_W - 1);
   localparam logic [TW-1:0] CHECK_LAST = TW'(2);
   localparam logic [TW-1:0] T_ZERO     = {TW{1'b0}};
   localparam logic [TW-1:0] T_ONE      = TW'(1);

   localparam logic [1:0] OP_CLEAR = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_DOWN  = 2'b10;
   localparam logic [1:0] OP_LOAD  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ACT   = 2'b01,
      S_GAP   = 2'b10,
      S_CHECK = 2'b11
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_timer;
   logic [TW-1:0] w_timer_nxt;
   logic [4:0]    r_pcnt;
   logic [4:0]    w_pcnt_nxt;
   logic [1:0]    r_op;
   logic [1:0]    w_op_nxt;
   logic          w_strobe_on;
   logic          w_accept;
   logic          w_done_nxt;
   logic [4:0]    w_first_n;

   logic          r_ready;
   logic          r_up;
   logic          r_down;
   logic          r_nload;
   logic          r_clr;
   logic [3:0]    r_d;
   logic [3:0]    r_exp;
   logic          r_done;
   logic [3:0]    r_result;
   logic          r_err;
   logic          r_co_seen;
   logic          r_bo_seen;

   logic [3:0]    r_q_m;
   logic [3:0]    r_q_s;
   logic          r_co_m;
   logic          r_co_s;
   logic          r_bo_m;
   logic          r_bo_s;

   // Counter value after a command; count 0 means 16 pulses, which is a no-op modulo 16.
   function automatic logic [3:0] next_expected(
      input logic [1:0] op,
      input logic [3:0] cur,
      input logic [3:0] cnt,
      input logic [3:0] data
   );
      logic [3:0] nxt;
      case (op)
         OP_CLEAR: nxt = 4'd0;
         OP_UP:    nxt = cur + cnt;
         OP_DOWN:  nxt = cur - cnt;
         OP_LOAD:  nxt = data;
         default:  nxt = cur;
      endcase
      return nxt;
   endfunction

   assign w_first_n = ((cmd_op == OP_UP) || (cmd_op == OP_DOWN)) ?
                      ((cmd_cnt == 4'd0) ? 5'd16 : {1'b0, cmd_cnt}) : 5'd1;

   // Next-state, timer and strobe-enable decode for the command sequencer.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_pcnt_nxt  = r_pcnt;
      w_op_nxt    = r_op;
      w_strobe_on = 1'b0;
      w_accept    = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               w_accept    = 1'b1;
               w_op_nxt    = cmd_op;
               w_pcnt_nxt  = w_first_n;
               w_timer_nxt = PULSE_LAST;
               w_strobe_on = 1'b1;
               w_state_nxt = S_ACT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ACT: begin
            if (r_timer == T_ZERO) begin
               w_pcnt_nxt  = r_pcnt - 5'd1;
               w_timer_nxt = GAP_LAST;
               w_state_nxt = S_GAP;
            end else begin
               w_timer_nxt = r_timer - T_ONE;
               w_strobe_on = 1'b1;
            end
         end
         S_GAP: begin
            if (r_timer != T_ZERO) begin
               w_timer_nxt = r_timer - T_ONE;
            end else if (r_pcnt != 5'd0) begin
               w_timer_nxt = PULSE_LAST;
               w_strobe_on = 1'b1;
               w_state_nxt = S_ACT;
            end else begin
               w_timer_nxt = CHECK_LAST;
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            // Two settle cycles let the last strobe's effect pass the synchronizers.
            if (r_timer == T_ZERO) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_timer_nxt = r_timer - T_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = T_ZERO;
            w_pcnt_nxt  = 5'd0;
         end
      endcase
   end

   // Sequencer state and registered strobes; nclr forces strobes inactive immediately.
   always_ff @(posedge clk or negedge nclr) begin
      if (!nclr) begin
         r_state <= S_IDLE;
         r_timer <= T_ZERO;
         r_pcnt  <= 5'd0;
         r_op    <= OP_CLEAR;
         r_ready <= 1'b1;
         r_up    <= 1'b1;
         r_down  <= 1'b1;
         r_nload <= 1'b1;
         r_clr   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_op    <= w_op_nxt;
         r_ready <= (w_state_nxt == S_IDLE);
         r_up    <= !(w_strobe_on && (w_op_nxt == OP_UP));
         r_down  <= !(w_strobe_on && (w_op_nxt == OP_DOWN));
         r_nload <= !(w_strobe_on && (w_op_nxt == OP_LOAD));
         r_clr   <= w_strobe_on && (w_op_nxt == OP_CLEAR);
      end
   end

   // Two-flop synchronizers for the asynchronous counter outputs.
   always_ff @(posedge clk or negedge nclr) begin
      if (!nclr) begin
         r_q_m  <= 4'd0;
         r_q_s  <= 4'd0;
         r_co_m <= 1'b1;
         r_co_s <= 1'b1;
         r_bo_m <= 1'b1;
         r_bo_s <= 1'b1;
      end else begin
         r_q_m  <= q;
         r_q_s  <= r_q_m;
         r_co_m <= co;
         r_co_s <= r_co_m;
         r_bo_m <= bo;
         r_bo_s <= r_bo_m;
      end
   end

   // Tracked value, parallel data, completion report and sticky carry/borrow flags.
   always_ff @(posedge clk or negedge nclr) begin
      if (!nclr) begin
         r_exp     <= 4'd0;
         r_d       <= 4'd0;
         r_done    <= 1'b0;
         r_result  <= 4'd0;
         r_err     <= 1'b0;
         r_co_seen <= 1'b0;
         r_bo_seen <= 1'b0;
      end else begin
         if (w_accept) begin
            r_exp <= next_expected(cmd_op, r_exp, cmd_cnt, cmd_data);
            if (cmd_op == OP_LOAD) begin
               r_d <= cmd_data;
            end else begin
               r_d <= r_d;
            end
         end else begin
            r_exp <= r_exp;
            r_d   <= r_d;
         end

         r_done <= w_done_nxt;
         if (w_done_nxt) begin
            r_result <= r_q_s;
            r_err    <= (r_q_s != r_exp);
         end else begin
            r_result <= r_result;
            r_err    <= 1'b0;
         end

         if (w_accept) begin
            r_co_seen <= 1'b0;
            r_bo_seen <= 1'b0;
         end else if (r_state != S_IDLE) begin
            r_co_seen <= r_co_seen | !r_co_s;
            r_bo_seen <= r_bo_seen | !r_bo_s;
         end else begin
            r_co_seen <= r_co_seen;
            r_bo_seen <= r_bo_seen;
         end
      end
   end

   assign cmd_ready = r_ready;
   assign up        = r_up;
   assign down      = r_down;
   assign nload     = r_nload;
   assign clr       = r_clr;
   assign d         = r_d;
   assign done      = r_done;
   assign result    = r_result;
   assign err       = r_err;
   assign co_seen   = r_co_seen;
   assign bo_seen   = r_bo_seen;

endmodule

// File: tb/tb_sn193_ctrl.sv
// Bench for sn193_ctrl wired to a behavioural '193 counter; completions are checked against a scoreboard.
`timescale 1ns/1ps
module tb_sn193_ctrl;

   logic       clk = 1'b0;
   logic       nclr = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_op = 2'd0;
   logic [3:0] cmd_cnt = 4'd0;
   logic [3:0] cmd_data = 4'd0;
   logic       cmd_ready, up, down, nload, clr, done, err, co_seen, bo_seen;
   logic [3:0] d, result;

   logic [3:0] chip_q = 4'd0;
   logic       prev_up = 1'b1;
   logic       prev_down = 1'b1;
   logic       q_stuck = 1'b0;
   logic [3:0] q_pin;
   logic       co_pin, bo_pin;

   typedef struct {
      logic [3:0] res;
      logic       err;
      logic       co;
      logic       bo;
      int         lat;
   } sb_t;

   sb_t sb_q[$];
   int  acc_q[$];
   int  cyc = 0;
   int  last_acc = -1;
   int  acc_total = 0;
   int  n_checks = 0;
   int  n_errors = 0;
   int  m_chip = 0;
   int  m_exp = 0;

   sn193_ctrl #(.PULSE_W(4), .GAP_W(4)) dut (
      .clk(clk), .nclr(nclr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
      .up(up), .down(down), .nload(nload), .clr(clr), .d(d),
      .q(q_pin), .co(co_pin), .bo(bo_pin),
      .done(done), .result(result), .err(err), .co_seen(co_seen), .bo_seen(bo_seen)
   );

   always #5 clk = ~clk;

   // Asynchronous '193: clear dominates, then load, then rising edges of up/down count.
   always @(clr or nload or up or down or d) begin
      if (clr === 1'b1) chip_q = 4'd0;
      else if (nload === 1'b0) chip_q = d;
      else if (up === 1'b1 && prev_up === 1'b0) chip_q = chip_q + 4'd1;
      else if (down === 1'b1 && prev_down === 1'b0) chip_q = chip_q - 4'd1;
      prev_up = up;
      prev_down = down;
   end

   assign q_pin  = q_stuck ? 4'd0 : chip_q;
   assign co_pin = !((chip_q == 4'd15) && (up == 1'b0));
   assign bo_pin = !((chip_q == 4'd0) && (down == 1'b0));

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (!nclr) acc_q.delete();
      else if (cmd_valid && cmd_ready) begin
         acc_q.push_back(cyc);
         last_acc = cyc;
         acc_total = acc_total + 1;
      end
   end

   // Scoreboard: every done pulse is matched against the oldest expected completion.
   always @(negedge clk) begin
      if (nclr && done) begin
         sb_t e;
         int  a;
         if (sb_q.size() == 0 || acc_q.size() == 0) begin
            n_checks = n_checks + 1;
            n_errors = n_errors + 1;
            $display("FAIL unexpected_done: done=1 at cycle %0d, required no completion", cyc);
         end else begin
            e = sb_q.pop_front();
            a = acc_q.pop_front();
            n_checks = n_checks + 5;
            if (result !== e.res) begin
               n_errors = n_errors + 1;
               $display("FAIL result: got %0d required %0d", result, e.res);
            end
            if (err !== e.err) begin
               n_errors = n_errors + 1;
               $display("FAIL err: got %b required %b", err, e.err);
            end
            if (co_seen !== e.co) begin
               n_errors = n_errors + 1;
               $display("FAIL co_seen: got %b required %b", co_seen, e.co);
            end
            if (bo_seen !== e.bo) begin
               n_errors = n_errors + 1;
               $display("FAIL bo_seen: got %b required %b", bo_seen, e.bo);
            end
            if ((cyc - a) !== e.lat) begin
               n_errors = n_errors + 1;
               $display("FAIL latency: got %0d required %0d", cyc - a, e.lat);
            end
         end
      end
   end

   // Reference model of the counter and of the controller's tracked value.
   function automatic sb_t model_step(input int op, input int cnt, input int data);
      sb_t e;
      int  n;
      n = (op == 1 || op == 2) ? ((cnt == 0) ? 16 : cnt) : 1;
      e.co = 1'b0;
      e.bo = 1'b0;
      case (op)
         0: begin m_chip = 0; m_exp = 0; end
         1: begin e.co = (m_chip + n >= 16); m_chip = (m_chip + n) % 16; m_exp = (m_exp + n) % 16; end
         2: begin e.bo = (n > m_chip); m_chip = (m_chip - n + 32) % 16; m_exp = (m_exp - n + 32) % 16; end
         default: begin m_chip = data; m_exp = data; end
      endcase
      e.res = q_stuck ? 4'd0 : 4'(m_chip);
      e.err = (int'(e.res) != m_exp);
      e.lat = n * 8 + 3;
      return e;
   endfunction

   task automatic do_cmd(input int op, input int cnt, input int data);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!cmd_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      sb_q.push_back(model_step(op, cnt, data));
      cmd_op = 2'(op);
      cmd_cnt = 4'(cnt);
      cmd_data = 4'(data);
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      waited = 0;
      while (sb_q.size() != 0 && waited < 400) begin
         @(posedge clk);
         waited++;
      end
      if (sb_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: op=%0d pending=%0d required 0", op, sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic test_reset();
      nclr = 1'b0;
      cmd_valid = 1'b1;
      cmd_op = 2'b01;
      cmd_cnt = 4'd1;
      repeat (3) @(negedge clk);
      n_checks += 4;
      if ({up, down, nload, clr} !== 4'b1110) begin
         n_errors++;
         $display("FAIL reset_strobes: got %b required 1110", {up, down, nload, clr});
      end
      if ({done, err, co_seen, bo_seen} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_flags: got %b required 0000", {done, err, co_seen, bo_seen});
      end
      if (result !== 4'd0 || d !== 4'd0) begin
         n_errors++;
         $display("FAIL reset_data: result=%0d d=%0d required 0 0", result, d);
      end
      if (acc_total !== 0) begin
         n_errors++;
         $display("FAIL reset_accept: got %0d accepts required 0", acc_total);
      end
      cmd_valid = 1'b0;
      nclr = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_ready: got %b required 1", cmd_ready);
      end
   endtask

   task automatic test_clear_up();
      do_cmd(0, 0, 0);
      do_cmd(1, 5, 0);
   endtask

   task automatic test_load_up();
      do_cmd(3, 0, 14);
      do_cmd(1, 3, 0);
      n_checks++;
      if (d !== 4'd14) begin
         n_errors++;
         $display("FAIL d_hold: got %0d required 14", d);
      end
   endtask

   task automatic test_down();
      do_cmd(0, 0, 0);
      do_cmd(2, 0, 0);
      do_cmd(2, 1, 0);
   endtask

   task automatic test_back_to_back();
      int a0, dn, d1, bad, waited;
      a0 = acc_total;
      dn = 0;
      d1 = 0;
      bad = 0;
      waited = 0;
      @(negedge clk);
      sb_q.push_back(model_step(1, 2, 0));
      sb_q.push_back(model_step(1, 2, 0));
      cmd_op = 2'b01;
      cmd_cnt = 4'd2;
      cmd_valid = 1'b1;
      while (dn < 2 && waited < 200) begin
         @(negedge clk);
         waited++;
         if (done) begin
            dn++;
            if (dn == 1) d1 = cyc;
            else cmd_valid = 1'b0;
         end else if (cmd_ready) begin
            bad++;
         end
         if (dn == 1 && cyc == d1 + 1) begin
            n_checks++;
            if (last_acc !== d1 + 1) begin
               n_errors++;
               $display("FAIL b2b_start: second accept at %0d required %0d", last_acc, d1 + 1);
            end
         end
      end
      cmd_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_checks += 3;
      if (dn !== 2) begin
         n_errors++;
         $display("FAIL b2b_dones: got %0d required 2", dn);
      end
      if (acc_total - a0 !== 2) begin
         n_errors++;
         $display("FAIL b2b_accepts: got %0d required 2", acc_total - a0);
      end
      if (bad !== 0) begin
         n_errors++;
         $display("FAIL b2b_ready_busy: ready high on %0d busy cycles required 0", bad);
      end
      sb_q.delete();
   endtask

   task automatic test_abort();
      @(negedge clk);
      cmd_op = 2'b01;
      cmd_cnt = 4'd4;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      n_checks++;
      if (up !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_act: up=%b required 0", up);
      end
      @(negedge clk);
      #2 nclr = 1'b0;
      #1;
      n_checks++;
      if (up !== 1'b1 || cmd_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL abort_async: up=%b ready=%b required 1 1", up, cmd_ready);
      end
      m_chip = (m_chip + 1) % 16;
      m_exp = 0;
      repeat (2) @(negedge clk);
      nclr = 1'b1;
      @(negedge clk);
      n_checks++;
      if (cmd_ready !== 1'b1 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL abort_idle: ready=%b done=%b required 1 0", cmd_ready, done);
      end
      q_stuck = 1'b1;
      do_cmd(1, 1, 0);
      q_stuck = 1'b0;
      do_cmd(0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_clear_up();
      test_load_up();
      test_down();
      test_back_to_back();
      test_abort();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
